// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a single-port data memory with a one-cycle read path.
// Supports round-robin or fixed priority, plus bounded grant locking per port.
module data_memory_arbiter #(
    parameter int RR       = 1,
    parameter int MAX_HOLD = 8,
    parameter int DATA_W   = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic              B_REQ,
    input  logic              A_WE,
    input  logic              B_WE,
    input  logic              A_LOCK,
    input  logic              B_LOCK,
    input  logic [DATA_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic              A_GNT,
    output logic              B_GNT,
    output logic              A_RVALID,
    output logic              B_RVALID,
    output logic [DATA_W-1:0] A_RDATA,
    output logic [DATA_W-1:0] B_RDATA,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RDATA
);
    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_ptr_b;
    logic                w_ptr_b_next;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_hold_next;
    logic                r_rd_a;
    logic                r_rd_b;
    logic [DATA_W-1:0]   r_last_addr;
    logic [DATA_W-1:0]   r_last_wdata;
    logic                w_gnt_a;
    logic                w_gnt_b;
    logic                w_preempt;
    logic                w_pick_a;
    logic                w_owner_gnt;
    logic                w_lock_gnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_ptr_b      <= 1'b0;
            r_hold       <= '0;
            r_rd_a       <= 1'b0;
            r_rd_b       <= 1'b0;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr_b <= w_ptr_b_next;
            r_hold  <= w_hold_next;
            r_rd_a  <= w_gnt_a && !A_WE;
            r_rd_b  <= w_gnt_b && !B_WE;
            if (w_gnt_a || w_gnt_b) begin
                r_last_addr  <= MEM_ADDR;
                r_last_wdata <= MEM_WDATA;
            end
        end
    end

    always_comb begin
        w_gnt_a      = 1'b0;
        w_gnt_b      = 1'b0;
        w_preempt    = 1'b0;
        w_pick_a     = A_REQ && (!B_REQ || (RR == 0) || !r_ptr_b);
        if (RST_N) begin
            case (r_state)
                OWN_A: begin
                    if (A_REQ) begin
                        if (B_REQ && (r_hold == HOLD_MAX)) begin
                            w_gnt_b   = 1'b1;
                            w_preempt = 1'b1;
                        end else begin
                            w_gnt_a = 1'b1;
                        end
                    end else begin
                        w_gnt_b = B_REQ;
                    end
                end
                OWN_B: begin
                    if (B_REQ) begin
                        if (A_REQ && (r_hold == HOLD_MAX)) begin
                            w_gnt_a   = 1'b1;
                            w_preempt = 1'b1;
                        end else begin
                            w_gnt_b = 1'b1;
                        end
                    end else begin
                        w_gnt_a = A_REQ;
                    end
                end
                default: begin
                    w_gnt_a = w_pick_a;
                    w_gnt_b = B_REQ && !w_pick_a;
                end
            endcase
        end

        // Grants to the current owner keep the pointer; every other grant hands it to the other port.
        w_owner_gnt  = ((r_state == OWN_A) && w_gnt_a) || ((r_state == OWN_B) && w_gnt_b);
        w_lock_gnt   = (w_gnt_a && A_LOCK) || (w_gnt_b && B_LOCK);
        w_state_next = IDLE;
        w_hold_next  = '0;
        w_ptr_b_next = r_ptr_b;
        if (w_owner_gnt) begin
            if (w_lock_gnt) begin
                w_state_next = r_state;
                w_hold_next  = (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;
            end
        end else if (w_gnt_a || w_gnt_b) begin
            w_ptr_b_next = w_gnt_a;
            if (w_lock_gnt && !w_preempt) begin
                w_state_next = w_gnt_a ? OWN_A : OWN_B;
                w_hold_next  = HOLD_W'(1);
            end
        end
    end

    assign A_GNT     = w_gnt_a;
    assign B_GNT     = w_gnt_b;
    assign MEM_WE    = (w_gnt_a && A_WE) || (w_gnt_b && B_WE);
    assign MEM_ADDR  = w_gnt_a ? A_ADDR  : (w_gnt_b ? B_ADDR  : r_last_addr);
    assign MEM_WDATA = w_gnt_a ? A_WDATA : (w_gnt_b ? B_WDATA : r_last_wdata);
    assign A_RVALID  = r_rd_a && RST_N;
    assign B_RVALID  = r_rd_b && RST_N;
    assign A_RDATA   = A_RVALID ? MEM_RDATA : '0;
    assign B_RDATA   = B_RVALID ? MEM_RDATA : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: instance 0 is round-robin with hold 8, instance 1 fixed priority with hold 3.
// Both share stimulus; a per-cycle reference model checks every output of both instances.
module tb_data_memory_arbiter;
    logic        clk;
    logic        rst_n;
    logic        a_req, b_req, a_we, b_we, a_lock, b_lock;
    logic [15:0] a_addr, b_addr, a_wdata, b_wdata;

    logic [1:0]  a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we;
    logic [15:0] a_rdata [2];
    logic [15:0] b_rdata [2];
    logic [15:0] mem_addr [2];
    logic [15:0] mem_wdata [2];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [15:0] mem [0:255];
        logic [15:0] rd_q;

        data_memory_arbiter #(
            .RR       (gi == 0 ? 1 : 0),
            .MAX_HOLD (gi == 0 ? 8 : 3),
            .DATA_W   (16)
        ) u_dut (
            .CLK       (clk),
            .RST_N     (rst_n),
            .A_REQ     (a_req),
            .B_REQ     (b_req),
            .A_WE      (a_we),
            .B_WE      (b_we),
            .A_LOCK    (a_lock),
            .B_LOCK    (b_lock),
            .A_ADDR    (a_addr),
            .B_ADDR    (b_addr),
            .A_WDATA   (a_wdata),
            .B_WDATA   (b_wdata),
            .A_GNT     (a_gnt[gi]),
            .B_GNT     (b_gnt[gi]),
            .A_RVALID  (a_rvalid[gi]),
            .B_RVALID  (b_rvalid[gi]),
            .A_RDATA   (a_rdata[gi]),
            .B_RDATA   (b_rdata[gi]),
            .MEM_ADDR  (mem_addr[gi]),
            .MEM_WDATA (mem_wdata[gi]),
            .MEM_WE    (mem_we[gi]),
            .MEM_RDATA (rd_q)
        );

        initial begin
            for (int k = 0; k < 256; k++) mem[k] <= 16'h0000;
            mem[0] <= 16'h1234;
            mem[1] <= 16'h5678;
            mem[7] <= 16'h7777;
        end

        always @(posedge clk) begin
            if (mem_we[gi]) mem[mem_addr[gi][7:0]] <= mem_wdata[gi];
            rd_q <= mem[mem_addr[gi][7:0]];
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
        end
    endtask

    // Reference model: owner (0 none, 1 A, 2 B), turn pointer (0 A, 1 B), run length of locked grants,
    // pending read owner and its expected data, last bus values and a shadow memory.
    bit          m_init = 1'b0;
    int          m_own [2];
    int          m_ptr [2];
    int          m_hold [2];
    int          m_rdq [2];
    logic [15:0] m_rdexp [2];
    logic [15:0] m_last [2];
    logic [15:0] m_lastw [2];
    logic [15:0] m_mem [2][256];

    task automatic model_step(input int i);
        int          g;
        bit          pre;
        int          mx;
        bit          rr;
        logic        we_g, lock_g, ev_a, ev_b;
        logic [15:0] ad, wd;
        mx  = (i == 0) ? 8 : 3;
        rr  = (i == 0);
        g   = 0;
        pre = 1'b0;
        if (rst_n) begin
            if (m_own[i] == 1 && a_req) begin
                if (b_req && m_hold[i] == mx) begin g = 2; pre = 1'b1; end
                else g = 1;
            end else if (m_own[i] == 2 && b_req) begin
                if (a_req && m_hold[i] == mx) begin g = 1; pre = 1'b1; end
                else g = 2;
            end else if (a_req && b_req) begin
                g = (rr && m_ptr[i] == 1) ? 2 : 1;
            end else if (a_req) begin
                g = 1;
            end else if (b_req) begin
                g = 2;
            end
        end
        we_g   = (g == 1) ? a_we   : ((g == 2) ? b_we   : 1'b0);
        lock_g = (g == 1) ? a_lock : ((g == 2) ? b_lock : 1'b0);
        ad     = (g == 1) ? a_addr  : ((g == 2) ? b_addr  : m_last[i]);
        wd     = (g == 1) ? a_wdata : ((g == 2) ? b_wdata : m_lastw[i]);
        ev_a   = rst_n && (m_rdq[i] == 1);
        ev_b   = rst_n && (m_rdq[i] == 2);

        if (m_init) begin
            chk("m_a_gnt",     i, a_gnt[i],     g == 1);
            chk("m_b_gnt",     i, b_gnt[i],     g == 2);
            chk("m_mem_we",    i, mem_we[i],    we_g);
            chk("m_mem_addr",  i, mem_addr[i],  ad);
            chk("m_mem_wdata", i, mem_wdata[i], wd);
            chk("m_a_rvalid",  i, a_rvalid[i],  ev_a);
            chk("m_b_rvalid",  i, b_rvalid[i],  ev_b);
            chk("m_a_rdata",   i, a_rdata[i],   ev_a ? m_rdexp[i] : 16'h0);
            chk("m_b_rdata",   i, b_rdata[i],   ev_b ? m_rdexp[i] : 16'h0);
        end

        if (!rst_n) begin
            m_own[i] = 0; m_ptr[i] = 0; m_hold[i] = 0; m_rdq[i] = 0;
            m_last[i] = 16'h0; m_lastw[i] = 16'h0;
        end else if (m_init) begin
            if (g != 0 && we_g) m_mem[i][ad[7:0]] = wd;
            if (g != 0 && !we_g) begin
                m_rdq[i]   = g;
                m_rdexp[i] = m_mem[i][ad[7:0]];
            end else begin
                m_rdq[i] = 0;
            end
            if (g != 0) begin m_last[i] = ad; m_lastw[i] = wd; end
            if (pre) begin
                m_own[i] = 0; m_hold[i] = 0; m_ptr[i] = (g == 1) ? 1 : 0;
            end else if (g != 0 && g == m_own[i]) begin
                if (lock_g) m_hold[i] = (m_hold[i] + 1 > mx) ? mx : m_hold[i] + 1;
                else begin m_own[i] = 0; m_hold[i] = 0; end
            end else if (g != 0) begin
                m_ptr[i] = (g == 1) ? 1 : 0;
                if (lock_g) begin m_own[i] = g; m_hold[i] = 1; end
                else begin m_own[i] = 0; m_hold[i] = 0; end
            end else begin
                m_own[i] = 0; m_hold[i] = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 256; k++) m_mem[i][k] = 16'h0000;
            m_mem[i][0] = 16'h1234;
            m_mem[i][1] = 16'h5678;
            m_mem[i][7] = 16'h7777;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) model_step(i);
            if (!rst_n) m_init = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic ga, gb;

    initial begin
        rst_n = 1'b0; a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_lock = 0; b_lock = 0;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
        cyc();
        // Requests and writes during reset must be ignored.
        a_req = 1; b_req = 1; a_we = 1; b_we = 1; a_addr = 3; b_addr = 4;
        a_wdata = 16'h1111; b_wdata = 16'h2222;
        for (int k = 0; k < 2; k++) begin
            smp();
            for (int i = 0; i < 2; i++) begin
                chk("rst_a_gnt", i, a_gnt[i], 0);
                chk("rst_b_gnt", i, b_gnt[i], 0);
                chk("rst_mem_we", i, mem_we[i], 0);
                chk("rst_a_rvalid", i, a_rvalid[i], 0);
                chk("rst_mem_addr", i, mem_addr[i], 0);
                chk("rst_mem_wdata", i, mem_wdata[i], 0);
            end
            cyc();
        end

        rst_n = 1; a_we = 0; b_we = 0; a_addr = 0; b_addr = 1;
        smp();
        for (int i = 0; i < 2; i++) begin
            chk("first_arb_a", i, a_gnt[i], 1);
            chk("first_arb_b", i, b_gnt[i], 0);
        end
        cyc();
        a_req = 0;
        smp();
        for (int i = 0; i < 2; i++) begin
            chk("rd0_b_gnt", i, b_gnt[i], 1);
            chk("rd0_a_rvalid", i, a_rvalid[i], 1);
            chk("rd0_a_rdata", i, a_rdata[i], 16'h1234);
            chk("rd0_b_rvalid", i, b_rvalid[i], 0);
        end
        cyc();
        b_req = 0;
        smp();
        for (int i = 0; i < 2; i++) begin
            chk("rd1_b_rvalid", i, b_rvalid[i], 1);
            chk("rd1_b_rdata", i, b_rdata[i], 16'h5678);
            chk("rd1_a_rvalid", i, a_rvalid[i], 0);
        end
        cyc();

        // Both ports reading address 1 continuously: alternation vs fixed priority.
        a_req = 1; b_req = 1; a_addr = 1; b_addr = 1;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("rr_a_gnt", 0, a_gnt[0], (k % 2) == 0);
            chk("rr_b_gnt", 0, b_gnt[0], (k % 2) == 1);
            chk("fp_a_gnt", 1, a_gnt[1], 1);
            chk("fp_b_gnt", 1, b_gnt[1], 0);
            if (k > 0) begin
                chk("rr_a_rvalid", 0, a_rvalid[0], (k % 2) == 1);
                chk("rr_b_rvalid", 0, b_rvalid[0], (k % 2) == 0);
                chk("rr_rdata", 0, ((k % 2) == 1) ? a_rdata[0] : b_rdata[0], 16'h5678);
            end
            cyc();
        end
        a_req = 0; b_req = 0;
        smp();
        chk("rr_last_b_rvalid", 0, b_rvalid[0], 1);
        chk("rr_last_b_rdata", 0, b_rdata[0], 16'h5678);
        cyc();

        // Write then immediate read of the same address.
        b_req = 1; b_we = 1; b_addr = 5; b_wdata = 16'hBEEF;
        smp();
        for (int i = 0; i < 2; i++) begin
            chk("wr_b_gnt", i, b_gnt[i], 1);
            chk("wr_mem_we", i, mem_we[i], 1);
            chk("wr_mem_addr", i, mem_addr[i], 5);
            chk("wr_mem_wdata", i, mem_wdata[i], 16'hBEEF);
        end
        cyc();
        b_req = 0; b_we = 0; a_req = 1; a_addr = 5;
        smp();
        for (int i = 0; i < 2; i++) begin
            chk("raw_a_gnt", i, a_gnt[i], 1);
            chk("raw_b_rvalid", i, b_rvalid[i], 0);
            chk("raw_mem_we", i, mem_we[i], 0);
        end
        cyc();
        a_req = 0;
        smp();
        for (int i = 0; i < 2; i++) begin
            chk("raw_a_rvalid", i, a_rvalid[i], 1);
            chk("raw_a_rdata", i, a_rdata[i], 16'hBEEF);
            chk("idle_mem_addr_held", i, mem_addr[i], 5);
            chk("idle_mem_we", i, mem_we[i], 0);
        end
        cyc();

        // A locks while B waits: eight grants to A, one to B, then A again.
        a_req = 1; a_lock = 1; a_addr = 1; b_addr = 0;
        for (int k = 0; k < 10; k++) begin
            b_req = (k > 0);
            smp();
            chk("hold_a_gnt", 0, a_gnt[0], k != 8);
            chk("hold_b_gnt", 0, b_gnt[0], k == 8);
            cyc();
        end
        a_req = 0; b_req = 0; a_lock = 0;
        smp();
        cyc();

        // Reset in the cycle after a read grant.
        a_req = 1; a_addr = 0;
        smp();
        for (int i = 0; i < 2; i++) chk("pre_rst_a_gnt", i, a_gnt[i], 1);
        cyc();
        rst_n = 0; a_req = 0; b_req = 1; b_we = 1; b_addr = 7; b_wdata = 16'hDEAD;
        smp();
        for (int i = 0; i < 2; i++) begin
            chk("rst_sup_a_rvalid", i, a_rvalid[i], 0);
            chk("rst_sup_a_rdata", i, a_rdata[i], 0);
            chk("rst_sup_mem_we", i, mem_we[i], 0);
            chk("rst_sup_b_gnt", i, b_gnt[i], 0);
        end
        cyc();
        rst_n = 1; a_req = 1; a_addr = 1; b_we = 0;
        smp();
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_a_gnt", i, a_gnt[i], 1);
            chk("post_rst_b_gnt", i, b_gnt[i], 0);
            chk("post_rst_a_rvalid", i, a_rvalid[i], 0);
        end
        cyc();
        a_req = 0;
        smp();
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_rdata", i, a_rdata[i], 16'h5678);
            chk("post_rst_b_gnt2", i, b_gnt[i], 1);
        end
        cyc();
        b_req = 0;
        smp();
        for (int i = 0; i < 2; i++) chk("no_spurious_wr", i, b_rdata[i], 16'h7777);
        cyc();

        // Randomized traffic; each port holds its transaction until instance 0 grants it.
        ga = 1'b1; gb = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (!a_req || ga) begin
                a_req   = ($urandom_range(0, 3) != 0);
                a_we    = 1'($urandom_range(0, 1));
                a_lock  = 1'($urandom_range(0, 1));
                a_addr  = 16'($urandom_range(0, 15));
                a_wdata = 16'($urandom);
            end
            if (!b_req || gb) begin
                b_req   = ($urandom_range(0, 3) != 0);
                b_we    = 1'($urandom_range(0, 1));
                b_lock  = 1'($urandom_range(0, 1));
                b_addr  = 16'($urandom_range(0, 15));
                b_wdata = 16'($urandom);
            end
            rst_n = ($urandom_range(0, 149) != 0);
            smp();
            ga = a_gnt[0];
            gb = b_gnt[0];
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
